// File: rtl/serial_digit_comp.sv
// serial_digit_comp: accumulates MSB-first 2-bit digit compare flags into a full-width magnitude result
module serial_digit_comp #(
  parameter int NDIGITS = 4,
  parameter int CNTW = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic dig_valid,
  input  logic dig_greater,
  input  logic dig_smaller,
  input  logic dig_equal,
  output logic busy,
  output logic done,
  output logic greater,
  output logic smaller,
  output logic equal,
  output logic err
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t r_state, w_next;
  logic [CNTW-1:0] r_cnt;
  logic r_dec, r_gt, r_lt, r_err, r_res;
  logic w_acc, w_last, w_onehot;
  assign w_acc = (r_state == SCAN) && dig_valid && !start;
  assign w_last = r_cnt == CNTW'(NDIGITS - 1);
  assign w_onehot = $onehot({dig_greater, dig_smaller, dig_equal});
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (start) w_next = SCAN;
    else if (r_state == DONE) w_next = IDLE;
    else if (w_acc && w_last) w_next = DONE;
  end
  // r_res marks a completed comparison so that outputs stay 0 before the first one
  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_cnt <= '0;
      r_dec <= 1'b0;
      r_gt  <= 1'b0;
      r_lt  <= 1'b0;
      r_err <= 1'b0;
      r_res <= 1'b0;
    end else if (w_acc) begin
      r_cnt <= r_cnt + 1'b1;
      if (!w_onehot) r_err <= 1'b1;
      else if (!r_dec && !dig_equal) begin
        r_dec <= 1'b1;
        r_gt  <= dig_greater;
        r_lt  <= dig_smaller;
      end
      if (w_last) r_res <= 1'b1;
    end
  end
  always_comb begin
    busy    = r_state == SCAN;
    done    = r_state == DONE;
    greater = r_res && r_gt;
    smaller = r_res && r_lt;
    equal   = r_res && !r_dec;
    err     = r_err;
  end
endmodule

// File: tb/tb_serial_digit_comp.sv
// tb_serial_digit_comp: directed scenario tasks for serial_digit_comp with NDIGITS=4
module tb_serial_digit_comp;
  logic clk = 0, rst = 0, start = 0, dig_valid = 0;
  logic dig_greater = 0, dig_smaller = 0, dig_equal = 0;
  logic busy, done, greater, smaller, equal, err;
  int n_tests = 0, n_fail = 0;
  localparam logic [1:0] EQ = 0, GT = 1, LT = 2, BAD = 3;

  serial_digit_comp #(.NDIGITS(4), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dig_valid(dig_valid),
    .dig_greater(dig_greater), .dig_smaller(dig_smaller), .dig_equal(dig_equal),
    .busy(busy), .done(done), .greater(greater), .smaller(smaller),
    .equal(equal), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] c);
    dig_valid   = v;
    dig_greater = (c == GT) || (c == BAD);
    dig_smaller = (c == LT) || (c == BAD);
    dig_equal   = (c == EQ);
  endtask

  task automatic begin_cmp();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    start = 1;
    drive(1, GT);
    tick();
    rst = 0;
    start = 0;
    drive(0, EQ);
    n_tests++;
    if ({busy, done, greater, smaller, equal, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset: outs=%b required 000000", {busy, done, greater, smaller, equal, err});
    end
  endtask

  task automatic test_gt();
    logic [1:0] seq [4] = '{EQ, GT, LT, EQ};
    begin_cmp();
    n_tests++;
    if (busy !== 1'b1 || greater !== 1'b0) begin
      n_fail++;
      $display("FAIL gt_start: busy=%b greater=%b required 1 0", busy, greater);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, seq[i]);
      tick();
      drive(0, EQ);
      if (i < 3) begin
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL gt_scan%0d: done=%b busy=%b required 0 1", i, done, busy);
        end
      end
    end
    n_tests++;
    if ({busy, done, greater, smaller, equal, err} !== 6'b011000) begin
      n_fail++;
      $display("FAIL gt_done: outs=%b required 011000", {busy, done, greater, smaller, equal, err});
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if ({busy, done, greater, smaller, equal, err} !== 6'b001000) begin
        n_fail++;
        $display("FAIL gt_hold%0d: outs=%b required 001000", i, {busy, done, greater, smaller, equal, err});
      end
    end
  endtask

  task automatic test_gaps();
    int gaps [4] = '{0, 3, 1, 2};
    begin_cmp();
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        drive(0, GT);
        tick();
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL gap%0d_%0d: busy=%b done=%b required 1 0", i, g, busy, done);
        end
      end
      drive(1, EQ);
      tick();
      drive(0, EQ);
      if (i < 3) begin
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL gap_dig%0d: busy=%b done=%b required 1 0", i, busy, done);
        end
      end
    end
    n_tests++;
    if ({busy, done, greater, smaller, equal, err} !== 6'b010010) begin
      n_fail++;
      $display("FAIL gap_done: outs=%b required 010010", {busy, done, greater, smaller, equal, err});
    end
    tick();
    n_tests++;
    if (done !== 1'b0 || equal !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_after: done=%b equal=%b required 0 1", done, equal);
    end
  endtask

  task automatic test_first_wins_err();
    logic [1:0] seq [4] = '{LT, GT, GT, GT};
    logic [1:0] bad [4] = '{BAD, EQ, EQ, EQ};
    begin_cmp();
    for (int i = 0; i < 4; i++) begin
      drive(1, seq[i]);
      tick();
    end
    drive(0, EQ);
    n_tests++;
    if ({done, greater, smaller, equal, err} !== 5'b10100) begin
      n_fail++;
      $display("FAIL first_wins: outs=%b required 10100", {done, greater, smaller, equal, err});
    end
    tick();
    begin_cmp();
    for (int i = 0; i < 4; i++) begin
      drive(1, bad[i]);
      tick();
      if (i == 0) begin
        n_tests++;
        if (err !== 1'b1) begin
          n_fail++;
          $display("FAIL err_set: err=%b required 1", err);
        end
      end
    end
    drive(0, EQ);
    n_tests++;
    if ({done, greater, smaller, equal, err} !== 5'b10011) begin
      n_fail++;
      $display("FAIL err_done: outs=%b required 10011", {done, greater, smaller, equal, err});
    end
    tick();
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b required 1", err);
    end
    begin_cmp();
    n_tests++;
    if (err !== 1'b0 || equal !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b equal=%b required 0 0", err, equal);
    end
  endtask

  task automatic test_restart();
    logic [1:0] seq [4] = '{EQ, EQ, EQ, LT};
    begin_cmp();
    drive(1, GT);
    tick();
    drive(1, EQ);
    tick();
    start = 1;
    drive(1, GT);
    tick();
    start = 0;
    drive(0, EQ);
    n_tests++;
    if ({busy, done, greater} !== 3'b100) begin
      n_fail++;
      $display("FAIL restart: busy/done/gt=%b required 100", {busy, done, greater});
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, seq[i]);
      tick();
      if (i < 3) begin
        n_tests++;
        if (done !== 1'b0) begin
          n_fail++;
          $display("FAIL restart_early%0d: done=%b required 0", i, done);
        end
      end
    end
    drive(0, EQ);
    n_tests++;
    if ({done, greater, smaller, equal} !== 4'b1010) begin
      n_fail++;
      $display("FAIL restart_done: outs=%b required 1010", {done, greater, smaller, equal});
    end
    tick();
  endtask

  task automatic test_rst_mid();
    begin_cmp();
    for (int i = 0; i < 3; i++) begin
      drive(1, GT);
      tick();
    end
    rst = 1;
    tick();
    rst = 0;
    n_tests++;
    if ({busy, done, greater, smaller, equal, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL rst_mid: outs=%b required 000000", {busy, done, greater, smaller, equal, err});
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, GT);
      tick();
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_ignore%0d: done=%b busy=%b required 0 0", i, done, busy);
      end
    end
    drive(0, EQ);
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [4] = '{LT, EQ, EQ, EQ};
    begin_cmp();
    for (int i = 0; i < 4; i++) begin
      drive(1, GT);
      tick();
    end
    drive(0, EQ);
    start = 1;
    n_tests++;
    if (done !== 1'b1 || greater !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: done=%b greater=%b required 1 1", done, greater);
    end
    tick();
    start = 0;
    n_tests++;
    if ({busy, done, greater, smaller, equal} !== 5'b10000) begin
      n_fail++;
      $display("FAIL b2b_clear: outs=%b required 10000", {busy, done, greater, smaller, equal});
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, seq[i]);
      tick();
    end
    drive(0, EQ);
    n_tests++;
    if ({done, greater, smaller, equal, err} !== 5'b10100) begin
      n_fail++;
      $display("FAIL b2b_second: outs=%b required 10100", {done, greater, smaller, equal, err});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_gt();
    test_gaps();
    test_first_wins_err();
    test_restart();
    test_rst_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
